// File: rtl/toeplitz_vec_buf.sv
// Stores ROW+COL-1 generator words of a Toeplitz matrix and serves them by address to a consumer.
// Zero-latency read in SERVE; loading is blocked (in_ready low) from the last word until the consumer finishes.
module toeplitz_vec_buf #(
   parameter int ROW   = 4,
   parameter int COL   = 4,
   parameter int WIDTH = 16,
   parameter int ADDR  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             start,
   input  logic             rd,
   input  logic [ADDR-1:0]  addr,
   output logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             err
);

   localparam int DEPTH = ROW + COL - 1;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so the range check never wraps regardless of ADDR.
   localparam logic [ADDR:0] DEPTH_X = (ADDR + 1)'(DEPTH);

   typedef enum logic [1:0] {LOAD, ARM, SERVE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic             rd_seen;
   logic             xfer;
   logic             last;
   logic             oob;

   assign in_ready = (state == LOAD);
   assign busy     = (state != LOAD);
   assign xfer     = in_valid && in_ready;
   assign last     = (wptr == PW'(DEPTH - 1));
   assign oob      = ({1'b0, addr} >= DEPTH_X);

   always_comb begin
      state_next = state;
      case (state)
         LOAD:    if (xfer && last) state_next = ARM;
         ARM:     state_next = SERVE;
         SERVE:   if (rd_seen && !rd) state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= LOAD;
         wptr    <= '0;
         rd_seen <= 1'b0;
         start   <= 1'b0;
         err     <= 1'b0;
      end else begin
         state <= state_next;
         start <= xfer && last;
         if (xfer) wptr <= last ? '0 : wptr + PW'(1);
         if (state == SERVE) begin
            if (rd && oob) err <= 1'b1;
            if (rd_seen && !rd) rd_seen <= 1'b0;
            else if (rd)        rd_seen <= 1'b1;
         end
      end
   end

   // Storage has no reset; reset only suppresses a coincident write.
   always_ff @(posedge clk) begin
      if (xfer && !rst) mem[wptr] <= in_data;
   end

   always_comb begin
      data = '0;
      if (state == SERVE && !oob) data = mem[addr[PW-1:0]];
   end

endmodule
